// File: rtl/emmc_req_arbiter.sv
// rtl/emmc_req_arbiter.sv - shares one emmc_sm block-transfer port between N_REQ requesters
//
// Purpose: picks one requester, issues a single start strobe to emmc_sm with that
// requester's we/blk_idx/blk_cnt, routes data strobes to the granted port only, and
// reports completion with an error flag when the byte count is wrong, the block
// count is zero, or emmc_sm never acknowledges the start.
//
// Ports:
//   clk_i, arst_ni          clock, asynchronous active-low reset
//   req_*_i                 per-requester request level, direction, block index/count, write data
//   req_dat_o/req_dvalid_o  read data (broadcast) and per-port data strobe
//   req_done_o/req_err_o    per-port one-cycle completion pulse and its error flag
//   grant_o, busy_o         current/last grant index, arbiter not idle
//   sm_*                    connection to emmc_sm (start/we/blk_idx/blk_cnt/dat, dat/dvalid/ready)
//
// Configuration: define EMMC_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// round-robin otherwise.
module emmc_req_arbiter #(
   parameter int N_REQ         = 2,
   parameter int BLK_CNT_WIDTH = 16,
   parameter int BLK_BYTES     = 512,
   parameter int ACK_TIMEOUT   = 64
) (
   input  logic                                  clk_i,
   input  logic                                  arst_ni,
   input  logic [N_REQ-1:0]                      req_i,
   input  logic [N_REQ-1:0]                      req_we_i,
   input  logic [N_REQ-1:0][15:0]                req_blk_idx_i,
   input  logic [N_REQ-1:0][BLK_CNT_WIDTH-1:0]   req_blk_cnt_i,
   input  logic [N_REQ-1:0][7:0]                 req_dat_i,
   output logic [7:0]                            req_dat_o,
   output logic [N_REQ-1:0]                      req_dvalid_o,
   output logic [N_REQ-1:0]                      req_done_o,
   output logic [N_REQ-1:0]                      req_err_o,
   output logic [$clog2(N_REQ)-1:0]              grant_o,
   output logic                                  busy_o,
   output logic                                  sm_start_o,
   output logic                                  sm_we_o,
   output logic [15:0]                           sm_blk_idx_o,
   output logic [BLK_CNT_WIDTH-1:0]              sm_blk_cnt_o,
   output logic [7:0]                            sm_dat_o,
   input  logic [7:0]                            sm_dat_i,
   input  logic                                  sm_dvalid_i,
   input  logic                                  sm_ready_i
);

   localparam int GW    = $clog2(N_REQ);
   localparam int LOG2B = $clog2(BLK_BYTES);
   localparam int CW    = BLK_CNT_WIDTH + LOG2B;
   localparam int TW    = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_BUSY, S_DONE} state_e;

   state_e                   state_q, state_d;
   logic [GW-1:0]            grant_q, rr_q, win, cand;
   logic                     win_vld;
   logic                     we_q;
   logic [15:0]              idx_q;
   logic [BLK_CNT_WIDTH-1:0] cnt_q;
   logic [CW-1:0]            bytes_q;
   logic [CW-1:0]            exp_bytes;
   logic [TW-1:0]            timer_q;
   logic                     fail_q;
   logic                     mask_q;
   logic                     timeout;
   logic [N_REQ-1:0]         grant_oh;
   logic [N_REQ-1:0]         req_eff;

   assign grant_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
   // The requester just completed may still hold req_i in the first IDLE cycle.
   assign req_eff   = req_i & ~(mask_q ? grant_oh : '0);
   assign exp_bytes = CW'(cnt_q) << LOG2B;
   assign timeout   = (state_q == S_WAIT_ACK) && sm_ready_i &&
                      (timer_q == TW'(ACK_TIMEOUT - 1));

   // Winner selection; the loop runs from lowest to highest priority so the last hit wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = '0;
`ifdef EMMC_ARB_FIXED_PRIO_EN
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = GW'(i);
         if (req_eff[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
`else
      for (int k = N_REQ; k >= 1; k--) begin
         cand = GW'((int'(rr_q) + k) % N_REQ);
         if (req_eff[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (win_vld && sm_ready_i) begin
               state_d = (req_blk_cnt_i[win] == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE:    state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (!sm_ready_i) begin
               state_d = S_BUSY;
            end else if (timeout) begin
               state_d = S_DONE;
            end
         end
         S_BUSY:     if (sm_ready_i) state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sm_start_o   = (state_q == S_ISSUE);
      busy_o       = (state_q != S_IDLE);
      req_dvalid_o = '0;
      req_dat_o    = '0;
      sm_dat_o     = '0;
      req_done_o   = '0;
      req_err_o    = '0;
      if (state_q == S_BUSY) begin
         req_dvalid_o = grant_oh & {N_REQ{sm_dvalid_i}};
         req_dat_o    = sm_dat_i;
         sm_dat_o     = req_dat_i[grant_q];
      end
      if (state_q == S_DONE) begin
         req_done_o = grant_oh;
         req_err_o  = (fail_q || (bytes_q != exp_bytes)) ? grant_oh : '0;
      end
   end

   // Grant registers change only in IDLE, so sm_* stay stable for the whole transfer.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         grant_q <= '0;
         rr_q    <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         bytes_q <= '0;
         timer_q <= '0;
         fail_q  <= 1'b0;
         mask_q  <= 1'b0;
      end else begin
         mask_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (win_vld && sm_ready_i) begin
                  grant_q <= win;
                  we_q    <= req_we_i[win];
                  idx_q   <= req_blk_idx_i[win];
                  cnt_q   <= req_blk_cnt_i[win];
                  fail_q  <= (req_blk_cnt_i[win] == '0);
               end
            end
            S_ISSUE:    timer_q <= '0;
            S_WAIT_ACK: begin
               bytes_q <= '0;
               timer_q <= timer_q + TW'(1);
               if (timeout) fail_q <= 1'b1;
            end
            S_BUSY: begin
               if (sm_dvalid_i && (bytes_q != '1)) bytes_q <= bytes_q + CW'(1);
            end
            S_DONE: begin
               rr_q   <= grant_q;
               mask_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign grant_o      = grant_q;
   assign sm_we_o      = we_q;
   assign sm_blk_idx_o = idx_q;
   assign sm_blk_cnt_o = cnt_q;

endmodule

// File: tb/tb_emmc_req_arbiter.sv
// tb/tb_emmc_req_arbiter.sv - scoreboard bench for emmc_req_arbiter with an emmc_sm model
module tb_emmc_req_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [1:0]       req, req_we;
   logic [1:0][15:0] req_idx, req_cnt;
   logic [1:0][7:0]  req_dat;
   logic [7:0]       req_dat_o;
   logic [1:0]       req_dvalid_o, req_done_o, req_err_o;
   logic [0:0]       grant_o;
   logic             busy_o, sm_start_o, sm_we_o;
   logic [15:0]      sm_blk_idx_o, sm_blk_cnt_o;
   logic [7:0]       sm_dat_o, sm_dat;
   logic             sm_dvalid, sm_ready;

   emmc_req_arbiter #(.N_REQ(2), .BLK_CNT_WIDTH(16), .BLK_BYTES(512), .ACK_TIMEOUT(64)) dut (
      .clk_i(clk), .arst_ni(rst_n),
      .req_i(req), .req_we_i(req_we), .req_blk_idx_i(req_idx), .req_blk_cnt_i(req_cnt),
      .req_dat_i(req_dat), .req_dat_o(req_dat_o), .req_dvalid_o(req_dvalid_o),
      .req_done_o(req_done_o), .req_err_o(req_err_o), .grant_o(grant_o), .busy_o(busy_o),
      .sm_start_o(sm_start_o), .sm_we_o(sm_we_o), .sm_blk_idx_o(sm_blk_idx_o),
      .sm_blk_cnt_o(sm_blk_cnt_o), .sm_dat_o(sm_dat_o), .sm_dat_i(sm_dat),
      .sm_dvalid_i(sm_dvalid), .sm_ready_i(sm_ready)
   );

   typedef struct {
      logic        grant;
      logic        we;
      logic [15:0] idx;
      logic [15:0] cnt;
   } start_t;
   typedef struct {
      logic [1:0] done;
      logic [1:0] err;
   } done_t;

   start_t start_q[$];
   done_t  done_q[$];

   int   checks = 0;
   int   errors = 0;
   int   strobe_cnt = 0;
   logic model_hold = 1'b0;
   logic model_short = 1'b0;
   logic in_busy = 1'b0;
   logic cur_grant = 1'b0;
   logic cur_we = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write data sources change every cycle so routing errors are visible.
   initial begin
      int cyc;
      cyc = 0;
      req_dat = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         req_dat[0] = 8'(cyc);
         req_dat[1] = 8'(cyc * 3 + 1);
      end
   end

   // emmc_sm model: drops ready after start, streams blk_cnt*512 strobes, raises ready.
   initial begin
      int n;
      sm_ready = 1'b1;
      sm_dvalid = 1'b0;
      sm_dat = '0;
      @(posedge rst_n);
      repeat (2) @(posedge clk);
      #1;
      sm_dvalid = 1'b1;
      sm_dat = 8'h5a;
      @(posedge clk);
      #1;
      sm_dvalid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (sm_start_o && rst_n && !model_hold) begin
            n = int'(sm_blk_cnt_o) * 512 - (model_short ? 1 : 0);
            @(posedge clk);
            #1;
            sm_ready = 1'b0;
            @(posedge clk);
            #1;
            in_busy = 1'b1;
            for (int i = 0; i < n && rst_n; i++) begin
               sm_dvalid = 1'b1;
               sm_dat = 8'(i * 7 + 3);
               @(posedge clk);
               #1;
            end
            sm_dvalid = 1'b0;
            in_busy = 1'b0;
            sm_ready = 1'b1;
         end
      end
   end

   // Monitor: pops expectations when the DUT presents start/done/data.
   initial begin
      start_t s;
      done_t  d;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (sm_start_o) begin
               if (start_q.size() == 0) begin
                  chk("unexpected_start", 32'(1), 32'(0));
               end else begin
                  s = start_q.pop_front();
                  chk("start_grant", 32'(grant_o), 32'(s.grant));
                  chk("start_we", 32'(sm_we_o), 32'(s.we));
                  chk("start_idx", 32'(sm_blk_idx_o), 32'(s.idx));
                  chk("start_cnt", 32'(sm_blk_cnt_o), 32'(s.cnt));
                  cur_grant = s.grant;
                  cur_we = s.we;
               end
            end
            if (req_done_o != 2'b00) begin
               if (done_q.size() == 0) begin
                  chk("unexpected_done", 32'(req_done_o), 32'(0));
               end else begin
                  d = done_q.pop_front();
                  chk("done_vec", 32'(req_done_o), 32'(d.done));
                  chk("err_vec", 32'(req_err_o), 32'(d.err));
               end
            end
            if (req_dvalid_o != 2'b00) strobe_cnt++;
            if (sm_dvalid) begin
               if (in_busy) begin
                  chk("dvalid_route", 32'(req_dvalid_o), 32'(2'b01 << cur_grant));
                  chk("rd_data", 32'(req_dat_o), 32'(sm_dat));
                  if (cur_we) chk("wr_data", 32'(sm_dat_o), 32'(req_dat[cur_grant]));
               end else begin
                  chk("stray_dvalid", 32'(req_dvalid_o), 32'(0));
               end
            end
         end
      end
   end

   task automatic wait_done(input int p, input int bound, output int elapsed);
      logic got;
      got = 1'b0;
      elapsed = 0;
      while (!got && elapsed <= bound) begin
         @(negedge clk);
         if (req_done_o[p]) got = 1'b1;
         else elapsed++;
      end
      if (!got) chk("done_timeout", 32'(0), 32'(1));
   endtask

   task automatic push_exp(input int p, input logic we, input logic [15:0] idx,
                           input logic [15:0] cnt, input logic exp_err);
      start_t s;
      done_t  d;
      if (cnt != 0) begin
         s.grant = p[0];
         s.we = we;
         s.idx = idx;
         s.cnt = cnt;
         start_q.push_back(s);
      end
      d.done = 2'(1 << p);
      d.err = exp_err ? 2'(1 << p) : 2'b00;
      done_q.push_back(d);
   endtask

   task automatic run_req(input int p, input logic we, input logic [15:0] idx,
                          input logic [15:0] cnt, input logic exp_err, input int bound,
                          output int elapsed);
      push_exp(p, we, idx, cnt, exp_err);
      @(posedge clk);
      #1;
      req_we[p] = we;
      req_idx[p] = idx;
      req_cnt[p] = cnt;
      req[p] = 1'b1;
      wait_done(p, bound, elapsed);
      @(posedge clk);
      #1;
      req[p] = 1'b0;
   endtask

   initial begin
      int el, n0, p, k, waited;
      rst_n = 1'b0;
      req = '0;
      req_we = '0;
      req_idx = '0;
      req_cnt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'({req_dat_o, req_dvalid_o, req_done_o, req_err_o, grant_o,
                                busy_o, sm_start_o, sm_we_o, sm_dat_o}), 32'(0));
      chk("reset_sm_fields", 32'({sm_blk_idx_o, sm_blk_cnt_o}), 32'(0));
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);

      // Single read on port 0.
      run_req(0, 1'b0, 16'd3, 16'd1, 1'b0, 2000, el);
      // Write on port 1, 512 strobes routed to port 1 only.
      n0 = strobe_cnt;
      run_req(1, 1'b1, 16'd9, 16'd1, 1'b0, 2000, el);
      chk("write_strobes", 32'(strobe_cnt - n0), 32'(512));

      // Both requesting: last grant was 1 so rotation gives 0,1,0,1.
      for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b0, (i % 2 == 0) ? 16'd10 : 16'd20, 16'd2, 1'b0);
      @(posedge clk);
      #1;
      req_idx[0] = 16'd10;
      req_idx[1] = 16'd20;
      req_cnt[0] = 16'd2;
      req_cnt[1] = 16'd2;
      req_we = 2'b00;
      req = 2'b11;
      for (k = 0; k < 4; k++) begin
         waited = 0;
         while (req_done_o == 2'b00 && waited < 3000) begin
            @(negedge clk);
            waited++;
         end
         if (req_done_o == 2'b00) chk("rr_done_timeout", 32'(0), 32'(1));
         p = req_done_o[1] ? 1 : 0;
         @(posedge clk);
         #1;
         if (k == 3) req = 2'b00;
         else req[p] = 1'b0;
         if (k < 2) begin
            @(posedge clk);
            #1;
            req[p] = 1'b1;
         end
      end
      repeat (4) @(posedge clk);

      // Zero block count: no start, error done within 3 cycles.
      run_req(0, 1'b0, 16'd4, 16'd0, 1'b1, 3, el);
      chk("zero_cnt_latency", 32'(el <= 3), 32'(1));

      // No acknowledge from emmc_sm: timeout error.
      model_hold = 1'b1;
      run_req(0, 1'b0, 16'd5, 16'd1, 1'b1, 200, el);
      chk("ack_timeout_latency", 32'(el >= 64 && el <= 70), 32'(1));
      model_hold = 1'b0;

      // Short transfer (511 strobes on one block): error.
      model_short = 1'b1;
      run_req(0, 1'b0, 16'd6, 16'd1, 1'b1, 2000, el);
      model_short = 1'b0;
      repeat (3) @(posedge clk);

      // Reset during BUSY aborts silently.
      begin
         start_t s;
         s.grant = 1'b0;
         s.we = 1'b0;
         s.idx = 16'd7;
         s.cnt = 16'd4;
         start_q.push_back(s);
      end
      @(posedge clk);
      #1;
      req_idx[0] = 16'd7;
      req_cnt[0] = 16'd4;
      req[0] = 1'b1;
      waited = 0;
      while (!in_busy && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      chk("reached_busy", 32'(in_busy), 32'(1));
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      req = 2'b00;
      @(negedge clk);
      chk("midreset_outputs", 32'({req_dat_o, req_dvalid_o, req_done_o, req_err_o, grant_o,
                                   busy_o, sm_start_o, sm_we_o, sm_dat_o}), 32'(0));
      chk("midreset_sm_fields", 32'({sm_blk_idx_o, sm_blk_cnt_o}), 32'(0));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      run_req(1, 1'b0, 16'd12, 16'd1, 1'b0, 2000, el);

      repeat (3) @(posedge clk);
      chk("start_q_drained", 32'(start_q.size()), 32'(0));
      chk("done_q_drained", 32'(done_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
